// File: rtl/shiftreg_seq_pkg.sv
// rtl/shiftreg_seq_pkg.sv - shared constants, types and opcode decode for shiftreg_seq
//   CMD_W and field positions describe the command word {op[14:12], rep[11:8], data[7:0]}.
//   state_t is the sequencer state; dp_t bundles the register-side control outputs.
package shiftreg_seq_pkg;

   localparam int CMD_W    = 15;
   localparam int OP_MSB   = 14;
   localparam int OP_LSB   = 12;
   localparam int REP_MSB  = 11;
   localparam int REP_LSB  = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   localparam logic [2:0] OP_CLEAR   = 3'b000;
   localparam logic [2:0] OP_SHL     = 3'b001;
   localparam logic [2:0] OP_SHR     = 3'b010;
   localparam logic [2:0] OP_GRAY_UP = 3'b011;
   localparam logic [2:0] OP_GRAY_DN = 3'b100;
   localparam logic [2:0] OP_INV     = 3'b101;
   localparam logic [2:0] OP_SWAP    = 3'b110;
   localparam logic [2:0] OP_LOAD    = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   typedef struct packed {
      logic       rs;
      logic       oc;
      logic [2:0] md;
      logic [7:0] a;
   } dp_t;

   // All-zero control word is a no-op for the register.
   localparam dp_t DP_IDLE = '0;

   function automatic dp_t decode_op(input logic [2:0] op, input logic [7:0] data);
      dp_t d;
      d = DP_IDLE;
      case (op)
         OP_CLEAR: begin
            d.rs = 1'b1;
         end
         OP_LOAD: begin
            d.md = OP_LOAD;
            d.a  = data;
         end
         default: begin
            d.oc = 1'b1;
            d.md = op;
            d.a  = data;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - command FIFO for shiftreg_seq
//   clk, rs (async active-low reset), push/wdata, pop/rdata (head, combinational),
//   flush (empties in one edge, wins over push/pop), full, empty.
module seq_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rs) begin
      if (!rs) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count guards every read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/shiftreg_seq.sv
// rtl/shiftreg_seq.sv - command sequencer driving an 8-bit multi-function shift register
//   clk, rs (async active-low reset); cmd_valid/cmd_ready/cmd command intake into seq_fifo;
//   dp_rs/dp_oc/dp_md/dp_a registered register controls; cmd_done final-issue pulse; busy.
//   Optional abort input (flush + force idle) when SEQ_ABORT_EN is defined.
module shiftreg_seq
   import shiftreg_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CMD_W-1:0] cmd,
   output logic             dp_rs,
   output logic             dp_oc,
   output logic [2:0]       dp_md,
   output logic [7:0]       dp_a,
   output logic             cmd_done,
`ifdef SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy
);

   state_t           state;
   logic [3:0]       cnt;
   dp_t              dp_q;
   logic             done_q;
   logic             rdy_en;
   logic             abort_i;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CMD_W-1:0] head;
   logic             push;
   logic             pop;
   logic [2:0]       head_op;
   logic [3:0]       head_rep;
   logic [7:0]       head_data;

`ifdef SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign head_op   = head[OP_MSB:OP_LSB];
   assign head_rep  = head[REP_MSB:REP_LSB];
   assign head_data = head[DATA_MSB:DATA_LSB];

   // rdy_en keeps cmd_ready low until the first edge out of reset.
   assign cmd_ready = rdy_en & ~fifo_full;
   assign push      = cmd_valid & cmd_ready & ~abort_i;
   // Pop from IDLE, or on the final issue cycle so commands chain without a bubble.
   assign pop       = ~abort_i & ~fifo_empty &
                      ((state == ST_IDLE) || ((state == ST_ISSUE) && (cnt == 4'd0)));

   seq_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rs    (rs),
      .push  (push),
      .pop   (pop),
      .flush (abort_i),
      .wdata (cmd),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rs) begin
      if (!rs) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rs) begin
      if (!rs) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         dp_q   <= DP_IDLE;
         done_q <= 1'b0;
      end else if (abort_i) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         dp_q   <= DP_IDLE;
         done_q <= 1'b0;
      end else if (pop) begin
         state  <= ST_ISSUE;
         cnt    <= head_rep;
         dp_q   <= decode_op(head_op, head_data);
         done_q <= (head_rep == 4'd0);
      end else if (state == ST_ISSUE) begin
         if (cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
            done_q <= (cnt == 4'd1);
         end else begin
            state  <= ST_IDLE;
            dp_q   <= DP_IDLE;
            done_q <= 1'b0;
         end
      end
   end

   assign dp_rs    = dp_q.rs;
   assign dp_oc    = dp_q.oc;
   assign dp_md    = dp_q.md;
   assign dp_a     = dp_q.a;
   assign cmd_done = done_q;
   assign busy     = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_shiftreg_seq.sv
// tb/tb_shiftreg_seq.sv - self-checking bench for shiftreg_seq
module tb_shiftreg_seq;

   localparam int DEPTH = 4;

   typedef struct {
      logic [14:0] c;
      int          start;
      int          fin;
   } ent_t;

   logic        clk = 1'b0;
   logic        rs = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [14:0] cmd = '0;
   logic        cmd_ready;
   logic        dp_rs;
   logic        dp_oc;
   logic [2:0]  dp_md;
   logic [7:0]  dp_a;
   logic        cmd_done;
   logic        busy;
`ifdef SEQ_ABORT_EN
   logic        abort = 1'b0;
`endif

   ent_t sched[$];
   int   edge_n;
   int   last_fin;
   bit   rdy_m;
   int   tests;
   int   fails;

   always #5 clk = ~clk;

   shiftreg_seq #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rs        (rs),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .dp_rs     (dp_rs),
      .dp_oc     (dp_oc),
      .dp_md     (dp_md),
      .dp_a      (dp_a),
      .cmd_done  (cmd_done),
`ifdef SEQ_ABORT_EN
      .abort     (abort),
`endif
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Commands accepted but not yet popped before edge e.
   function automatic int pending(input int e);
      int n;
      n = 0;
      foreach (sched[i]) if (sched[i].start >= e) n++;
      return n;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, " dp_rs"}, dp_rs, 0);
      chk({tag, " dp_oc"}, dp_oc, 0);
      chk({tag, " dp_md"}, dp_md, 0);
      chk({tag, " dp_a"}, dp_a, 0);
      chk({tag, " cmd_done"}, cmd_done, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " cmd_ready"}, cmd_ready, 0);
   endtask

   // Expected drive after edge e: the scheduled command covering e, decoded from the op rules.
   task automatic check_outputs(input int e);
      logic       x_rs, x_oc, x_done, x_busy;
      logic [2:0] x_md, op;
      logic [7:0] x_a;
      while (sched.size() > 0 && sched[0].fin < e) void'(sched.pop_front());
      x_rs = 0; x_oc = 0; x_md = 0; x_a = 0; x_done = 0; x_busy = 0;
      foreach (sched[i]) begin
         if (sched[i].fin >= e) x_busy = 1;
         if (sched[i].start <= e && e <= sched[i].fin) begin
            op = sched[i].c[14:12];
            if (op == 3'd0) x_rs = 1;
            else if (op == 3'd7) begin x_md = 3'd7; x_a = sched[i].c[7:0]; end
            else begin x_oc = 1; x_md = op; x_a = sched[i].c[7:0]; end
            x_done = (e == sched[i].fin);
         end
      end
      chk($sformatf("dp_rs@%0d", e), dp_rs, x_rs);
      chk($sformatf("dp_oc@%0d", e), dp_oc, x_oc);
      chk($sformatf("dp_md@%0d", e), dp_md, x_md);
      chk($sformatf("dp_a@%0d", e), dp_a, x_a);
      chk($sformatf("cmd_done@%0d", e), cmd_done, x_done);
      chk($sformatf("busy@%0d", e), busy, x_busy);
   endtask

   task automatic step(input bit v, input logic [14:0] c, output bit acc);
      bit   exp_rdy;
      ent_t en;
      cmd_valid = v;
      cmd = c;
      exp_rdy = rdy_m && (pending(edge_n) < DEPTH);
      chk($sformatf("cmd_ready@%0d", edge_n), cmd_ready, exp_rdy);
      @(posedge clk);
      acc = v && exp_rdy;
      if (acc) begin
         en.c = c;
         en.start = (last_fin + 1 > edge_n + 1) ? last_fin + 1 : edge_n + 1;
         en.fin = en.start + int'(c[11:8]);
         last_fin = en.fin;
         sched.push_back(en);
      end
      rdy_m = 1;
      #1;
      check_outputs(edge_n);
      edge_n++;
      cmd_valid = 0;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(0, '0, a);
   endtask

   task automatic do_reset();
      cmd_valid = 0;
      rs = 0;
      #1;
      check_idle("reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset_hold");
      sched.delete();
      rdy_m = 0;
      edge_n = 0;
      last_fin = -10;
      rs = 1;
   endtask

`ifdef SEQ_ABORT_EN
   task automatic step_abort(input logic [14:0] c);
      abort = 1;
      cmd_valid = 1;
      cmd = c;
      @(posedge clk);
      sched.delete();
      last_fin = -10;
      #1;
      abort = 0;
      cmd_valid = 0;
      check_outputs(edge_n);
      edge_n++;
   endtask
`endif

   initial begin
      bit          a;
      int          n, guard;
      logic [14:0] c;
      tests = 0;
      fails = 0;
      last_fin = -10;
      #2;
      do_reset();

      // First edge after release: ready still low, then rises.
      idle(1);
      // Single LOAD 0xA5 with rep=0.
      step(1, {3'b111, 4'd0, 8'hA5}, a);
      idle(3);
      // SHL with rep=3 -> four cycles.
      step(1, {3'b001, 4'd3, 8'h3C}, a);
      idle(6);
      // CLEAR x2 then GRAY_UP x3 back to back.
      step(1, {3'b000, 4'd1, 8'h11}, a);
      step(1, {3'b011, 4'd2, 8'h22}, a);
      idle(7);
      // Long first command, then five rep=0 commands fill the FIFO and chain.
      step(1, {3'b101, 4'd15, 8'h5A}, a);
      n = 0;
      guard = 0;
      while (n < 5 && guard < 60) begin
         step(1, {3'b110 - 3'(n % 3), 4'd0, 8'(8'h40 + n)}, a);
         if (a) n++;
         guard++;
      end
      chk("fill_all_accepted", n, 5);
      idle(12);

      // Reset during the 2nd of 8 repetitions with two queued.
      step(1, {3'b010, 4'd7, 8'h81}, a);
      step(1, {3'b100, 4'd1, 8'h82}, a);
      step(1, {3'b111, 4'd0, 8'h83}, a);
      do_reset();
      idle(3);

`ifdef SEQ_ABORT_EN
      step(1, {3'b011, 4'd6, 8'h91}, a);
      step(1, {3'b001, 4'd1, 8'h92}, a);
      idle(2);
      step_abort({3'b111, 4'd0, 8'h93});
      idle(3);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
            idle(1);
         end
         c[14:12] = 3'($urandom_range(0, 7));
         c[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
         c[7:0]   = 8'($urandom_range(0, 255));
         step($urandom_range(0, 99) < 55, c, a);
      end
      idle(80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shiftreg_seq.md
SHIFTREG_SEQ -- requirements
Module: shiftreg_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rs  input  1  reset; asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  FIFO can accept a command.
REQ-006 cmd  input  15  command word: [14:12] op, [11:8] rep, [7:0] data.
REQ-007 dp_rs  output  1  active-high synchronous clear to the 8-bit multi-function register.
REQ-008 dp_oc  output  1  output-control to the register.
REQ-009 dp_md  output  3  mode select to the register.
REQ-010 dp_a  output  8  load data to the register.
REQ-011 cmd_done  output  1  one-cycle pulse on the final issue cycle of each command.
REQ-012 busy  output  1  high while state is not IDLE or the FIFO is non-empty.
REQ-013 abort  input  1  flush request; present only with SEQ_ABORT_EN.

Function
REQ-014 A command SHALL be accepted at an edge where cmd_valid and cmd_ready are both high; cmd_ready = FIFO not full, with no bypass when full.
REQ-015 The FSM SHALL have two states: IDLE and ISSUE.
- IDLE with FIFO non-empty: pop at the next edge, load cnt=rep, enter ISSUE.
REQ-016 In ISSUE the block SHALL drive the command for rep+1 consecutive cycles. rep=0 means one cycle; rep=15 means 16 cycles.
REQ-017 On the final issue cycle (cnt==0), cmd_done SHALL be high.
- FIFO non-empty: pop the next command at that edge, with no idle bubble.
- FIFO empty: return to IDLE.
REQ-018 Decoded outputs SHALL be registered, valid from the pop edge.
- op=000 (CLEAR): dp_rs=1, dp_oc=0, dp_md=000.
- op=111 (LOAD): dp_oc=0, dp_md=111, dp_a=data.
- op=001..110: dp_oc=1, dp_md=op, dp_a=data.
REQ-019 In IDLE the outputs SHALL be dp_rs=0, dp_oc=0, dp_md=000, dp_a=0, which is a no-op for the register.
REQ-020 Latency: for a command accepted at edge k into an empty FIFO in IDLE, the first drive SHALL appear after edge k+1.
REQ-021 Push and pop at the same edge SHALL leave the FIFO count unchanged and keep order FIFO.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate count of width clog2(FIFO_DEPTH)+1 for full/empty.
REQ-023 cnt SHALL be 4-bit and SHALL decrement only in ISSUE with cnt>0; it never underflows.

Reset
REQ-024 While rs=0 the block SHALL hold state=IDLE, FIFO empty, cnt=0, and all outputs at the REQ-019 values.
- cmd_ready=0, cmd_done=0, busy=0.
REQ-025 Reset asserted mid-command SHALL discard remaining repetitions and queued commands, with no cmd_done.
REQ-026 cmd_ready SHALL rise on the first edge after rs deasserts.

Configuration
REQ-027 Macro SEQ_ABORT_EN SHALL control the abort feature.
- Defined: abort=1 at an edge empties the FIFO, forces IDLE with idle outputs, and suppresses cmd_done. A command offered in the same cycle is dropped; abort wins.
- Undefined: the abort port and its logic are absent, and all other behaviour is identical.

Structure
REQ-028 Package shiftreg_seq_pkg SHALL hold:
- opcode constants OP_CLEAR=000, OP_SHL=001, OP_SHR=010, OP_GRAY_UP=011, OP_GRAY_DN=100, OP_INV=101, OP_SWAP=110, OP_LOAD=111;
- CMD_W=15;
- field position constants;
- the state enum.
REQ-029 The FIFO SHALL be sub-module seq_fifo (parameterised width and depth, push/pop/full/empty/flush); the FSM and decode live in shiftreg_seq.

Verification
REQ-030 Reset, then push {111,0000,0xA5} -> dp_oc=0, dp_md=111, dp_a=0xA5 for exactly 1 cycle starting after edge k+1, cmd_done high that cycle, then idle outputs.
REQ-031 Push {001,0011,x} -> dp_oc=1, dp_md=001 for 4 cycles; cmd_done only on the 4th.
REQ-032 Push 5 commands back-to-back with rep=0 while the first issues -> cmd_ready low when 4 are queued; all 5 issue in order on consecutive cycles with no bubble.
REQ-033 Push {000,0001,x} then {011,0010,x} -> dp_rs=1 for 2 cycles, then dp_md=011 for 3 cycles; busy falls the cycle after the last.
REQ-034 Assert rs=0 on the 2nd of 8 repetitions with 2 queued -> outputs go idle immediately; after release the FIFO is empty, no cmd_done, busy=0.
REQ-035 (SEQ_ABORT_EN) abort=1 mid-ISSUE with cmd_valid=1 the same cycle -> idle next cycle, FIFO empty, offered command dropped.
